// File: rtl/lockin_stream_pkg.sv
// Shared types and constants for the lock-in sample serializer.
// Entry layout and frame word ordering live here so the FIFO and framer agree.
package lockin_stream_pkg;

    localparam int unsigned FRAME_WORDS    = 6;
    localparam logic [15:0] DEFAULT_HEADER = 16'hA5C3;

    typedef struct packed {
        logic [15:0] seq;
        logic [31:0] x;
        logic [31:0] y;
    } lockin_entry_t;

    typedef enum logic {
        StIdle,
        StSend
    } ser_state_e;

    // Word order on the link: sync, sequence, X high/low, Y high/low.
    function automatic logic [15:0] frame_word(input lockin_entry_t e,
                                               input logic [2:0]    idx,
                                               input logic [15:0]   header);
        logic [15:0] w;
        case (idx)
            3'd0:    w = header;
            3'd1:    w = e.seq;
            3'd2:    w = e.x[31:16];
            3'd3:    w = e.x[15:0];
            3'd4:    w = e.y[31:16];
            3'd5:    w = e.y[15:0];
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/lockin_sample_fifo.sv
// Single-clock FIFO of sample entries with a first-word-fall-through head.
// Pushes while full and pops while empty are ignored.
module lockin_sample_fifo
    import lockin_stream_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          push,
    input  lockin_entry_t wdata,
    input  logic          pop,
    output lockin_entry_t head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    lockin_entry_t mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          do_push, do_pop;

    always_comb begin
        full    = (count_q == (AW+1)'(DEPTH));
        empty   = (count_q == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;

        // DEPTH is a power of two, so the pointers wrap naturally.
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign level = count_q;

endmodule

// File: rtl/lockin_stream_serializer.sv
// Buffers lock-in X/Y pairs and emits each as a 6-word framed 16-bit stream
// with ready/valid backpressure; counts samples dropped on a full FIFO.
module lockin_stream_serializer
    import lockin_stream_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter logic [15:0] HEADER = DEFAULT_HEADER
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [31:0]              sample_x,
    input  logic [31:0]              sample_y,
    input  logic                     sample_valid,
    output logic [15:0]              out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [15:0]              overflow_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam logic [2:0] LastIdx = 3'(FRAME_WORDS - 1);

    ser_state_e    state_q, state_d;
    logic [2:0]    idx_q,   idx_d;
    lockin_entry_t frame_q, frame_d;
    logic [15:0]   seq_q,   seq_d;
    logic [15:0]   ovf_q,   ovf_d;

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic          accept, drop;
    lockin_entry_t fifo_head, fifo_wdata;

    lockin_sample_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (fifo_push),
        .wdata   (fifo_wdata),
        .pop     (fifo_pop),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Full is the pre-pop view, so a write racing a pop from a full FIFO is dropped.
    always_comb begin
        accept     = sample_valid && enable;
        fifo_push  = accept && !fifo_full;
        drop       = accept && fifo_full;
        fifo_wdata = '{seq: seq_q, x: sample_x, y: sample_y};

        seq_d = seq_q;
        if (!enable) begin
            seq_d = 16'h0000;
        end else if (sample_valid) begin
            seq_d = seq_q + 16'd1;
        end

        ovf_d = ovf_q;
        if (drop && (ovf_q != 16'hFFFF)) begin
            ovf_d = ovf_q + 16'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        frame_d   = frame_q;
        fifo_pop  = 1'b0;
        out_valid = 1'b0;
        out_data  = 16'h0000;
        out_last  = 1'b0;

        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    frame_d  = fifo_head;
                    idx_d    = 3'd0;
                    state_d  = StSend;
                end
            end
            StSend: begin
                out_valid = 1'b1;
                out_data  = frame_word(frame_q, idx_q, HEADER);
                out_last  = (idx_q == LastIdx);
                if (out_ready) begin
                    if (idx_q == LastIdx) begin
                        idx_d = 3'd0;
                        // Back-to-back frames: reload without an idle bubble.
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            frame_d  = fifo_head;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            idx_q   <= 3'd0;
            frame_q <= '0;
            seq_q   <= 16'h0000;
            ovf_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            seq_q   <= seq_d;
            ovf_q   <= ovf_d;
        end
    end

    assign overflow_count = ovf_q;

endmodule

// File: tb/tb_lockin_stream_serializer.sv
// Self-checking bench: constant frame vectors, directed corner sequences and
// random traffic against a queue-based transaction model.
module tb_lockin_stream_serializer;
    import lockin_stream_pkg::*;

    localparam int unsigned DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        sample_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] sample_x = '0;
    logic [31:0] sample_y = '0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic [15:0] overflow_count;
    logic [3:0]  fifo_level;

    lockin_stream_serializer #(
        .DEPTH  (DEPTH),
        .HEADER (16'hA5C3)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .enable         (enable),
        .sample_x       (sample_x),
        .sample_y       (sample_y),
        .sample_valid   (sample_valid),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last),
        .overflow_count (overflow_count),
        .fifo_level     (fifo_level)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Reference model: queued entries, the frame on the link, words left in it.
    lockin_entry_t mq[$];
    lockin_entry_t mframe;
    int            mrem;
    logic [15:0]   mseq;
    logic [15:0]   movf;
    logic [16:0]   got[$];

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [95:0] words;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mword(input lockin_entry_t e, input int k);
        logic [15:0] w [6];
        w = '{16'hA5C3, e.seq, e.x[31:16], e.x[15:0], e.y[31:16], e.y[15:0]};
        return w[k];
    endfunction

    task automatic model_clear();
        mq.delete();
        mframe = '0;
        mrem   = 0;
        mseq   = 16'h0000;
        movf   = 16'h0000;
    endtask

    task automatic model_step(input logic v, input logic [31:0] x, input logic [31:0] y,
                              input logic en, input logic rdy);
        bit was_full;
        was_full = (mq.size() == DEPTH);
        if (mrem == 0) begin
            if (mq.size() > 0) begin
                mframe = mq.pop_front();
                mrem   = 6;
            end
        end else if (rdy) begin
            mrem--;
            if (mrem == 0 && mq.size() > 0) begin
                mframe = mq.pop_front();
                mrem   = 6;
            end
        end
        if (v && en) begin
            if (!was_full) mq.push_back('{seq: mseq, x: x, y: y});
            else if (movf != 16'hFFFF) movf++;
        end
        if (!en) mseq = 16'h0000;
        else if (v) mseq++;
    endtask

    task automatic check_outputs();
        check("out_valid", 32'(out_valid), 32'(mrem > 0));
        check("out_data", 32'(out_data), (mrem > 0) ? 32'(mword(mframe, 6 - mrem)) : 32'h0);
        check("out_last", 32'(out_last), 32'(mrem == 1));
        check("fifo_level", 32'(fifo_level), 32'(mq.size()));
        check("overflow_count", 32'(overflow_count), 32'(movf));
    endtask

    // Called at a negedge; applies inputs for one rising edge and checks afterwards.
    task automatic tick(input logic v, input logic [31:0] x, input logic [31:0] y,
                        input logic en, input logic rdy);
        sample_valid = v;
        sample_x     = x;
        sample_y     = y;
        enable       = en;
        out_ready    = rdy;
        #1;
        if (out_valid && out_ready) got.push_back({out_last, out_data});
        @(posedge clock);
        model_step(v, x, y, en, rdy);
        @(negedge clock);
        check_outputs();
    endtask

    task automatic idle(input int n, input logic en, input logic rdy);
        for (int i = 0; i < n; i++) tick(1'b0, 32'h0, 32'h0, en, rdy);
    endtask

    task automatic do_reset();
        sample_valid = 1'b0;
        enable       = 1'b0;
        out_ready    = 1'b0;
        reset_n      = 1'b0;
        model_clear();
        got.delete();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check_outputs();
    endtask

    initial begin
        vecs[0] = '{32'h12345678, 32'hFEDCBA98, 96'hA5C3_0000_1234_5678_FEDC_BA98};
        vecs[1] = '{32'h00000000, 32'hFFFFFFFF, 96'hA5C3_0001_0000_0000_FFFF_FFFF};
        vecs[2] = '{32'h80000000, 32'h7FFFFFFF, 96'hA5C3_0002_8000_0000_7FFF_FFFF};
        vecs[3] = '{32'hDEADBEEF, 32'h00000001, 96'hA5C3_0003_DEAD_BEEF_0000_0001};

        do_reset();

        // Single samples from constant vectors, including first-word latency.
        for (int i = 0; i < 4; i++) begin
            got.delete();
            tick(1'b1, vecs[i].x, vecs[i].y, 1'b1, 1'b1);
            check("latency_before", 32'(out_valid), 32'h0);
            idle(1, 1'b1, 1'b1);
            check("latency_word0", 32'(out_valid), 32'h1);
            idle(7, 1'b1, 1'b1);
            check("vec_word_count", got.size(), 6);
            if (got.size() == 6) begin
                for (int k = 0; k < 6; k++) begin
                    check("vec_word", 32'(got[k][15:0]), 32'(vecs[i].words[95 - 16*k -: 16]));
                    check("vec_last", 32'(got[k][16]), 32'(k == 5));
                end
            end
        end

        // Four back-to-back strobes: 24 contiguous words.
        do_reset();
        for (int i = 0; i < 4; i++) tick(1'b1, 32'h1000 + i, 32'h2000 + i, 1'b1, 1'b1);
        idle(22, 1'b1, 1'b1);
        check("burst_words", got.size(), 24);
        if (got.size() == 24) begin
            for (int f = 0; f < 4; f++) check("burst_seq", 32'(got[6*f + 1][15:0]), f);
        end
        idle(1, 1'b1, 1'b1);
        check("burst_idle", 32'(out_valid), 32'h0);

        // Stalled sink with 12 strobes: 1 in flight, 8 queued, 3 dropped.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 32'hA000 + i, 32'hB000 + i, 1'b1, 1'b0);
            if (i == 8) check("stall_level_full", 32'(fifo_level), 8);
        end
        check("stall_overflow", 32'(overflow_count), 3);
        idle(59, 1'b1, 1'b1);
        tick(1'b1, 32'h5, 32'h6, 1'b1, 1'b1);
        idle(8, 1'b1, 1'b1);
        check("stall_frames", got.size(), 60);
        if (got.size() == 60) begin
            for (int f = 0; f < 9; f++) check("stall_seq", 32'(got[6*f + 1][15:0]), f);
            check("stall_seq_gap", 32'(got[55][15:0]), 12);
        end

        // Reset asserted while word 3 is on the link.
        do_reset();
        tick(1'b1, 32'hCAFEF00D, 32'h0BADBEEF, 1'b1, 1'b1);
        idle(4, 1'b1, 1'b1);
        check("pre_reset_word3", 32'(out_data), 32'hF00D);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'h0);
        check("async_rst_data", 32'(out_data), 32'h0);
        check("async_rst_last", 32'(out_last), 32'h0);
        check("async_rst_level", 32'(fifo_level), 32'h0);
        check("async_rst_ovf", 32'(overflow_count), 32'h0);
        model_clear();
        got.delete();
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        tick(1'b1, 32'h11112222, 32'h33334444, 1'b1, 1'b1);
        idle(8, 1'b1, 1'b1);
        check("post_reset_words", got.size(), 6);
        if (got.size() == 6) begin
            check("post_reset_hdr", 32'(got[0][15:0]), 32'hA5C3);
            check("post_reset_seq", 32'(got[1][15:0]), 32'h0);
        end

        // Disabled strobes are ignored; the queued frame still drains.
        do_reset();
        tick(1'b1, 32'h1, 32'h2, 1'b1, 1'b1);
        tick(1'b1, 32'h3, 32'h4, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) tick(1'b1, 32'h9, 32'h9, 1'b0, 1'b1);
        check("dis_frames", got.size(), 12);
        check("dis_overflow", 32'(overflow_count), 32'h0);
        check("dis_level", 32'(fifo_level), 32'h0);
        got.delete();
        tick(1'b1, 32'h77, 32'h88, 1'b1, 1'b1);
        idle(8, 1'b1, 1'b1);
        check("reen_words", got.size(), 6);
        if (got.size() == 6) check("reen_seq", 32'(got[1][15:0]), 32'h0);

        // Random traffic: light then heavy load, random backpressure and enable.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic v;
            v = (i < 300) ? ($urandom_range(0, 6) == 0) : ($urandom_range(0, 1) == 0);
            tick(v, $urandom, $urandom, $urandom_range(0, 19) != 0, $urandom_range(0, 2) != 0);
        end
        idle(80, 1'b1, 1'b1);
        check("rand_drained", 32'(fifo_level), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
